// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer for a DDS datapath.
// Steps a start phase increment by a signed step n_steps times, holding each
// frequency for max(dwell,1) cycles; single-shot or continuous operation.
// Every output is a register; the combinational process computes the value
// each output takes in the state being entered.
module dds_sweep_ctrl #(
    parameter int M  = 24,
    parameter int NW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          ic_rst,
    input  logic          ic_start,
    input  logic          ic_stop,
    input  logic          ic_continuous,
    input  logic [M-1:0]  id_f_start,
    input  logic [M-1:0]  id_f_step,
    input  logic [NW-1:0] id_n_steps,
    input  logic [DW-1:0] id_dwell,
    output logic [M-1:0]  od_p_ac,
    output logic          oc_en_ac,
    output logic          oc_rst_ac,
    output logic          oc_val_data,
    output logic          oc_busy,
    output logic          oc_done,
    output logic [NW-1:0] od_step_idx
);

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DONE} state_t;

    state_t        state_reg, state_next;

    // Sweep configuration captured when a sweep is accepted
    logic [M-1:0]  f_start_reg, f_start_next;
    logic [M-1:0]  f_step_reg, f_step_next;
    logic [NW-1:0] n_steps_reg, n_steps_next;
    logic [DW-1:0] dwell_reg, dwell_next;
    logic          cont_reg, cont_next;

    // Running sweep position
    logic [DW-1:0] dwell_cnt_reg, dwell_cnt_next;
    logic [NW-1:0] step_idx_reg, step_idx_next;

    // Output registers
    logic [M-1:0]  p_ac_reg, p_ac_next;
    logic          en_reg, en_next;
    logic          rst_ac_reg, rst_ac_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic          last_dwell;

    // dwell_reg is never 0 once latched, so dwell-1 cannot underflow in SWEEP
    assign last_dwell = (dwell_cnt_reg == dwell_reg - DW'(1));

    // Next-state and next-output decode
    always_comb begin
        state_next     = state_reg;
        f_start_next   = f_start_reg;
        f_step_next    = f_step_reg;
        n_steps_next   = n_steps_reg;
        dwell_next     = dwell_reg;
        cont_next      = cont_reg;
        dwell_cnt_next = dwell_cnt_reg;
        step_idx_next  = step_idx_reg;
        p_ac_next      = p_ac_reg;
        en_next        = 1'b0;
        rst_ac_next    = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                // Simultaneous start and stop is treated as no request
                if (ic_start && !ic_stop) begin
                    state_next    = LOAD;
                    f_start_next  = id_f_start;
                    f_step_next   = id_f_step;
                    n_steps_next  = id_n_steps;
                    dwell_next    = (id_dwell == '0) ? DW'(1) : id_dwell;
                    cont_next     = ic_continuous;
                    p_ac_next     = id_f_start;
                    step_idx_next = '0;
                    rst_ac_next   = 1'b1;
                    busy_next     = 1'b1;
                end
            end

            LOAD: begin
                if (ic_stop) begin
                    state_next = IDLE;
                end else begin
                    state_next     = SWEEP;
                    dwell_cnt_next = '0;
                    en_next        = 1'b1;
                    busy_next      = 1'b1;
                end
            end

            SWEEP: begin
                if (ic_stop) begin
                    state_next = IDLE;
                end else begin
                    en_next   = 1'b1;
                    busy_next = 1'b1;
                    if (!last_dwell) begin
                        dwell_cnt_next = dwell_cnt_reg + DW'(1);
                    end else begin
                        dwell_cnt_next = '0;
                        if (step_idx_reg < n_steps_reg) begin
                            p_ac_next     = p_ac_reg + f_step_reg;
                            step_idx_next = step_idx_reg + NW'(1);
                        end else if (cont_reg) begin
                            // Restart without resetting the accumulator: phase stays continuous
                            p_ac_next     = f_start_reg;
                            step_idx_next = '0;
                        end else begin
                            state_next = DONE;
                            en_next    = 1'b0;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (ic_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Configuration, sweep position and output registers
    always_ff @(posedge clk) begin
        if (ic_rst) begin
            f_start_reg   <= '0;
            f_step_reg    <= '0;
            n_steps_reg   <= '0;
            dwell_reg     <= DW'(1);
            cont_reg      <= 1'b0;
            dwell_cnt_reg <= '0;
            step_idx_reg  <= '0;
            p_ac_reg      <= '0;
            en_reg        <= 1'b0;
            rst_ac_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            f_start_reg   <= f_start_next;
            f_step_reg    <= f_step_next;
            n_steps_reg   <= n_steps_next;
            dwell_reg     <= dwell_next;
            cont_reg      <= cont_next;
            dwell_cnt_reg <= dwell_cnt_next;
            step_idx_reg  <= step_idx_next;
            p_ac_reg      <= p_ac_next;
            en_reg        <= en_next;
            rst_ac_reg    <= rst_ac_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign od_p_ac     = p_ac_reg;
    assign oc_en_ac    = en_reg;
    assign oc_val_data = en_reg;
    assign oc_rst_ac   = rst_ac_reg;
    assign oc_busy     = busy_reg;
    assign oc_done     = done_reg;
    assign od_step_idx = step_idx_reg;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed table, randomized sweeps
// against a per-cycle frequency list model, and hand-written corner sequences.
module tb_dds_sweep_ctrl;

    localparam int M  = 24;
    localparam int NW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          ic_rst;
    logic          ic_start;
    logic          ic_stop;
    logic          ic_continuous;
    logic [M-1:0]  id_f_start;
    logic [M-1:0]  id_f_step;
    logic [NW-1:0] id_n_steps;
    logic [DW-1:0] id_dwell;
    logic [M-1:0]  od_p_ac;
    logic          oc_en_ac;
    logic          oc_rst_ac;
    logic          oc_val_data;
    logic          oc_busy;
    logic          oc_done;
    logic [NW-1:0] od_step_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(.M(M), .NW(NW), .DW(DW)) dut (
        .clk           (clk),
        .ic_rst        (ic_rst),
        .ic_start      (ic_start),
        .ic_stop       (ic_stop),
        .ic_continuous (ic_continuous),
        .id_f_start    (id_f_start),
        .id_f_step     (id_f_step),
        .id_n_steps    (id_n_steps),
        .id_dwell      (id_dwell),
        .od_p_ac       (od_p_ac),
        .oc_en_ac      (oc_en_ac),
        .oc_rst_ac     (oc_rst_ac),
        .oc_val_data   (oc_val_data),
        .oc_busy       (oc_busy),
        .oc_done       (oc_done),
        .od_step_idx   (od_step_idx)
    );

    typedef struct {
        string         name;
        logic [M-1:0]  fs;
        logic [M-1:0]  fst;
        logic [NW-1:0] n;
        logic [DW-1:0] dw;
        bit            cont;
        int            reps;
        bit            scramble;
        int            exp_cycles;
        logic [M-1:0]  exp_last;
    } vec_t;

    vec_t tbl[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // {p_ac, step_idx, en, val, rst_ac, busy, done}
    function automatic logic [63:0] mk(input logic [M-1:0] p, input logic [NW-1:0] idx,
                                       input logic en, input logic rst,
                                       input logic busy, input logic done);
        return {19'd0, p, idx, en, en, rst, busy, done};
    endfunction

    function automatic logic [63:0] outs();
        return {19'd0, od_p_ac, od_step_idx, oc_en_ac, oc_val_data, oc_rst_ac, oc_busy, oc_done};
    endfunction

    function automatic logic [63:0] ctl();
        return {59'd0, oc_en_ac, oc_val_data, oc_rst_ac, oc_busy, oc_done};
    endfunction

    // Start a sweep and follow it cycle by cycle against the expected frequency list
    task automatic run_sweep(input vec_t v);
        logic [M-1:0]  model_p[$];
        logic [NW-1:0] model_i[$];
        logic [M-1:0]  tmp;
        logic [M-1:0]  last_p;
        int            hold;
        int            en_cnt;
        en_cnt = 0;
        last_p = '0;
        hold   = (v.dw == '0) ? 1 : int'(v.dw);
        // Each frequency f_start + s*f_step (mod 2^M) appears hold times, per repetition
        for (int r = 0; r < v.reps; r++) begin
            for (int s = 0; s <= int'(v.n); s++) begin
                tmp = v.fs + v.fst * M'(s);
                for (int d = 0; d < hold; d++) begin
                    model_p.push_back(tmp);
                    model_i.push_back(NW'(s));
                end
            end
        end

        id_f_start    = v.fs;
        id_f_step     = v.fst;
        id_n_steps    = v.n;
        id_dwell      = v.dw;
        ic_continuous = v.cont;
        ic_start      = 1'b1;
        ic_stop       = 1'b0;
        tick();
        ic_start = 1'b0;
        chk({v.name, " load"}, outs(), mk(v.fs, '0, 1'b0, 1'b1, 1'b1, 1'b0));

        for (int k = 0; k < model_p.size(); k++) begin
            if (v.scramble && k >= 1) begin
                id_f_start    = M'($urandom);
                id_f_step     = M'($urandom);
                id_n_steps    = NW'($urandom);
                id_dwell      = DW'($urandom);
                ic_continuous = 1'($urandom_range(0, 1));
                ic_start      = 1'($urandom_range(0, 1));
            end
            tick();
            chk($sformatf("%s sweep cycle %0d", v.name, k), outs(),
                mk(model_p[k], model_i[k], 1'b1, 1'b0, 1'b1, 1'b0));
            if (oc_en_ac) en_cnt++;
            last_p = od_p_ac;
        end
        ic_start = 1'b0;

        chk({v.name, " en_cycles"}, 64'(en_cnt), 64'(v.exp_cycles));
        chk({v.name, " last_p_ac"}, 64'(last_p), 64'(v.exp_last));

        if (!v.cont) begin
            tick();
            chk({v.name, " done"}, outs(), mk(v.exp_last, v.n, 1'b0, 1'b0, 1'b0, 1'b1));
            tick();
            chk({v.name, " idle_hold"}, outs(), mk(v.exp_last, v.n, 1'b0, 1'b0, 1'b0, 1'b0));
        end else begin
            ic_stop = 1'b1;
            tick();
            ic_stop = 1'b0;
            chk({v.name, " stopped"}, ctl(), 64'd0);
            tick();
            chk({v.name, " no_done"}, ctl(), 64'd0);
        end
        $display("run %s: fs=0x%06h step=0x%06h n=%0d dwell=%0d cont=%0d en_cycles=%0d",
                 v.name, v.fs, v.fst, v.n, v.dw, v.cont, en_cnt);
    endtask

    initial begin
        vec_t rv;
        bit   done_seen;
        int   h;

        ic_rst        = 1'b1;
        ic_start      = 1'b0;
        ic_stop       = 1'b0;
        ic_continuous = 1'b0;
        id_f_start    = '0;
        id_f_step     = '0;
        id_n_steps    = '0;
        id_dwell      = '0;

        tbl[0] = '{"single",  24'h000100, 24'h000100, 16'd3, 16'd4, 1'b0, 1, 1'b0, 16, 24'h000400};
        tbl[1] = '{"negwrap", 24'h000010, 24'hFFFFE0, 16'd2, 16'd1, 1'b0, 1, 1'b0,  3, 24'hFFFFD0};
        tbl[2] = '{"contin",  24'h000100, 24'h000100, 16'd3, 16'd4, 1'b1, 3, 1'b1, 48, 24'h000400};
        tbl[3] = '{"corner",  24'hABCDEF, 24'h000001, 16'd0, 16'd0, 1'b0, 1, 1'b0,  1, 24'hABCDEF};

        tick();
        tick();
        ic_rst = 1'b0;
        chk("reset_state", outs(), 64'd0);
        tick();
        chk("idle_after_reset", outs(), 64'd0);

        for (int i = 0; i < 4; i++) begin
            run_sweep(tbl[i]);
        end

        // start and stop together in IDLE: no LOAD
        ic_start = 1'b1;
        ic_stop  = 1'b1;
        tick();
        ic_start = 1'b0;
        ic_stop  = 1'b0;
        chk("start_stop_idle", ctl(), 64'd0);
        tick();
        chk("start_stop_idle2", ctl(), 64'd0);
        $display("run start+stop in idle");

        // Stop during the sweep at cycle 7, restart at cycle 10
        id_f_start    = 24'h000100;
        id_f_step     = 24'h000100;
        id_n_steps    = 16'd3;
        id_dwell      = 16'd4;
        ic_continuous = 1'b0;
        ic_start      = 1'b1;
        tick();                                  // cycle 1
        ic_start = 1'b0;
        repeat (6) tick();                       // cycle 7
        chk("stop_pre", outs(), mk(24'h000200, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0));
        ic_stop = 1'b1;
        tick();                                  // cycle 8
        ic_stop = 1'b0;
        chk("stop_idle", ctl(), 64'd0);
        done_seen = oc_done;
        tick();                                  // cycle 9
        done_seen = done_seen | oc_done;
        tick();                                  // cycle 10
        done_seen = done_seen | oc_done;
        chk("stop_no_done", 64'(done_seen), 64'd0);
        ic_start = 1'b1;
        tick();                                  // cycle 11
        ic_start = 1'b0;
        chk("restart_load", outs(), mk(24'h000100, '0, 1'b0, 1'b1, 1'b1, 1'b0));
        tick();                                  // cycle 12
        chk("restart_sweep", outs(), mk(24'h000100, '0, 1'b1, 1'b0, 1'b1, 1'b0));
        ic_stop = 1'b1;
        tick();
        ic_stop = 1'b0;
        chk("restart_stop", ctl(), 64'd0);
        $display("run stop@7 restart@10");

        // Reset mid-sweep at cycle 5
        ic_start = 1'b1;
        tick();                                  // cycle 1
        ic_start = 1'b0;
        repeat (4) tick();                       // cycle 5
        chk("rst_pre", outs(), mk(24'h000100, '0, 1'b1, 1'b0, 1'b1, 1'b0));
        ic_rst = 1'b1;
        tick();                                  // cycle 6
        ic_rst = 1'b0;
        chk("rst_mid", outs(), 64'd0);
        tick();
        chk("rst_mid_idle", outs(), 64'd0);
        $display("run reset@5");

        // Randomized sweeps with inputs scrambled while busy
        for (int i = 0; i < 8; i++) begin
            rv.name     = $sformatf("rand%0d", i);
            rv.fs       = M'($urandom);
            rv.fst      = M'($urandom);
            rv.n        = NW'($urandom_range(0, 5));
            rv.dw       = DW'($urandom_range(0, 4));
            rv.cont     = 1'($urandom_range(0, 1));
            rv.reps     = rv.cont ? 2 : 1;
            rv.scramble = 1'b1;
            h           = (rv.dw == '0) ? 1 : int'(rv.dw);
            rv.exp_cycles = (int'(rv.n) + 1) * h * rv.reps;
            rv.exp_last   = rv.fs + rv.fst * M'(rv.n);
            run_sweep(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
